// File: rtl/mem_port_arbiter.sv
// Shares one memory-controller port between the I-cache (line fills) and the
// D-cache (fills and write-backs). One transaction in flight at a time,
// round-robin arbitration between the two requesters, and each response is
// routed back to the requester that issued the request.
module mem_port_arbiter #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned LINE_W = 128
) (
    input  logic              i_clk,
    input  logic              i_reset,

    input  logic              i_ic_req_valid,
    output logic              o_ic_req_ready,
    input  logic [XLEN-1:0]   i_ic_addr,
    output logic              o_ic_resp_valid,
    output logic [LINE_W-1:0] o_ic_resp_data,

    input  logic              i_dc_req_valid,
    output logic              o_dc_req_ready,
    input  logic [XLEN-1:0]   i_dc_addr,
    input  logic              i_dc_we,
    input  logic [LINE_W-1:0] i_dc_wdata,
    output logic              o_dc_resp_valid,
    output logic [LINE_W-1:0] o_dc_resp_data,

    output logic              o_mem_req_valid,
    input  logic              i_mem_req_ready,
    output logic [XLEN-1:0]   o_mem_addr,
    output logic              o_mem_we,
    output logic [LINE_W-1:0] o_mem_wdata,
    input  logic              i_mem_resp_valid,
    input  logic [LINE_W-1:0] i_mem_resp_data,

    output logic              o_busy,
    output logic              o_owner_dc
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic              last_dc_q;
    logic              owner_dc_q;
    logic [XLEN-1:0]   addr_q;
    logic              we_q;
    logic [LINE_W-1:0] wdata_q;
    logic              ic_resp_valid_q;
    logic [LINE_W-1:0] ic_resp_data_q;
    logic              dc_resp_valid_q;
    logic [LINE_W-1:0] dc_resp_data_q;

    logic              grant_ic_c;
    logic              grant_dc_c;
    logic              accept_c;
    logic              resp_done_c;

    // Round-robin: on a tie the requester not granted last time wins.
    assign grant_ic_c  = i_ic_req_valid && (!i_dc_req_valid || last_dc_q);
    assign grant_dc_c  = i_dc_req_valid && (!i_ic_req_valid || !last_dc_q);
    assign accept_c    = (state_q == IDLE) && (grant_ic_c || grant_dc_c);
    assign resp_done_c = (state_q == RESP) && i_mem_resp_valid;

    // State register.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and request-side readies (only offered in IDLE).
    always_comb begin
        state_d        = state_q;
        o_ic_req_ready = 1'b0;
        o_dc_req_ready = 1'b0;
        case (state_q)
            IDLE: begin
                o_ic_req_ready = grant_ic_c;
                o_dc_req_ready = grant_dc_c;
                if (grant_ic_c || grant_dc_c) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (i_mem_req_ready) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (i_mem_resp_valid) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Latch the granted request and register the routed response pulse.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            last_dc_q       <= 1'b0;
            owner_dc_q      <= 1'b0;
            addr_q          <= '0;
            we_q            <= 1'b0;
            wdata_q         <= '0;
            ic_resp_valid_q <= 1'b0;
            ic_resp_data_q  <= '0;
            dc_resp_valid_q <= 1'b0;
            dc_resp_data_q  <= '0;
        end else begin
            ic_resp_valid_q <= 1'b0;
            dc_resp_valid_q <= 1'b0;
            if (accept_c) begin
                owner_dc_q <= grant_dc_c;
                last_dc_q  <= grant_dc_c;
                if (grant_dc_c) begin
                    addr_q  <= i_dc_addr;
                    we_q    <= i_dc_we;
                    wdata_q <= i_dc_we ? i_dc_wdata : '0;
                end else begin
                    addr_q  <= i_ic_addr;
                    we_q    <= 1'b0;
                    wdata_q <= '0;
                end
            end
            if (resp_done_c) begin
                if (owner_dc_q) begin
                    dc_resp_valid_q <= 1'b1;
                    dc_resp_data_q  <= we_q ? '0 : i_mem_resp_data;
                end else begin
                    ic_resp_valid_q <= 1'b1;
                    ic_resp_data_q  <= i_mem_resp_data;
                end
            end
        end
    end

    assign o_mem_req_valid = (state_q == REQ);
    assign o_busy          = (state_q != IDLE);
    assign o_owner_dc      = owner_dc_q;
    assign o_mem_addr      = addr_q;
    assign o_mem_we        = we_q;
    assign o_mem_wdata     = wdata_q;
    assign o_ic_resp_valid = ic_resp_valid_q;
    assign o_ic_resp_data  = ic_resp_data_q;
    assign o_dc_resp_valid = dc_resp_valid_q;
    assign o_dc_resp_data  = dc_resp_data_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of mem_port_arbiter: reset, single fills,
// tie alternation, stalled write-back, spurious responses, mid-flight reset.
module tb_mem_port_arbiter;
    localparam int unsigned XLEN   = 32;
    localparam int unsigned LINE_W = 128;

    logic              i_clk = 1'b0;
    logic              i_reset;
    logic              ic_v;
    logic              o_ic_req_ready;
    logic [XLEN-1:0]   ic_addr;
    logic              o_ic_resp_valid;
    logic [LINE_W-1:0] o_ic_resp_data;
    logic              dc_v;
    logic              o_dc_req_ready;
    logic [XLEN-1:0]   dc_addr;
    logic              dc_we;
    logic [LINE_W-1:0] dc_wdata;
    logic              o_dc_resp_valid;
    logic [LINE_W-1:0] o_dc_resp_data;
    logic              o_mem_req_valid;
    logic              mem_rdy;
    logic [XLEN-1:0]   o_mem_addr;
    logic              o_mem_we;
    logic [LINE_W-1:0] o_mem_wdata;
    logic              resp_v;
    logic [LINE_W-1:0] resp_data;
    logic              o_busy;
    logic              o_owner_dc;

    int n_cmp = 0;
    int n_err = 0;

    always #5 i_clk = ~i_clk;

    mem_port_arbiter #(.XLEN(XLEN), .LINE_W(LINE_W)) dut (
        .i_clk           (i_clk),
        .i_reset         (i_reset),
        .i_ic_req_valid  (ic_v),
        .o_ic_req_ready  (o_ic_req_ready),
        .i_ic_addr       (ic_addr),
        .o_ic_resp_valid (o_ic_resp_valid),
        .o_ic_resp_data  (o_ic_resp_data),
        .i_dc_req_valid  (dc_v),
        .o_dc_req_ready  (o_dc_req_ready),
        .i_dc_addr       (dc_addr),
        .i_dc_we         (dc_we),
        .i_dc_wdata      (dc_wdata),
        .o_dc_resp_valid (o_dc_resp_valid),
        .o_dc_resp_data  (o_dc_resp_data),
        .o_mem_req_valid (o_mem_req_valid),
        .i_mem_req_ready (mem_rdy),
        .o_mem_addr      (o_mem_addr),
        .o_mem_we        (o_mem_we),
        .o_mem_wdata     (o_mem_wdata),
        .i_mem_resp_valid(resp_v),
        .i_mem_resp_data (resp_data),
        .o_busy          (o_busy),
        .o_owner_dc      (o_owner_dc)
    );

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Caller drives the requester inputs while IDLE; this runs one
    // transaction with a memory model of given stall and response latency.
    task automatic run_txn(input bit exp_dc, input logic [XLEN-1:0] exp_addr,
                           input logic exp_we, input logic [LINE_W-1:0] exp_wdata,
                           input int stall, input int lat,
                           input logic [LINE_W-1:0] rdata,
                           input logic [LINE_W-1:0] exp_resp, input string tag);
        #1;
        chk1({tag, ".ic_ready"}, o_ic_req_ready, !exp_dc);
        chk1({tag, ".dc_ready"}, o_dc_req_ready, exp_dc);
        tick();
        if (exp_dc) dc_v = 1'b0;
        else        ic_v = 1'b0;
        chk1({tag, ".mem_valid"}, o_mem_req_valid, 1'b1);
        chk1({tag, ".owner"}, o_owner_dc, exp_dc);
        chkw({tag, ".addr"}, LINE_W'(o_mem_addr), LINE_W'(exp_addr));
        chk1({tag, ".we"}, o_mem_we, exp_we);
        chkw({tag, ".wdata"}, o_mem_wdata, exp_wdata);
        chk1({tag, ".busy"}, o_busy, 1'b1);
        chk1({tag, ".no_ready_req"}, o_ic_req_ready | o_dc_req_ready, 1'b0);
        for (int s = 0; s < stall; s++) begin
            tick();
            chk1({tag, ".stall_valid"}, o_mem_req_valid, 1'b1);
            chkw({tag, ".stall_addr"}, LINE_W'(o_mem_addr), LINE_W'(exp_addr));
            chk1({tag, ".stall_we"}, o_mem_we, exp_we);
            chkw({tag, ".stall_wdata"}, o_mem_wdata, exp_wdata);
        end
        mem_rdy = 1'b1;
        tick();
        mem_rdy = 1'b0;
        chk1({tag, ".resp_state_valid"}, o_mem_req_valid, 1'b0);
        chk1({tag, ".resp_state_busy"}, o_busy, 1'b1);
        repeat (lat) tick();
        resp_v    = 1'b1;
        resp_data = rdata;
        tick();
        resp_v    = 1'b0;
        resp_data = '0;
        chk1({tag, ".ic_resp_valid"}, o_ic_resp_valid, !exp_dc);
        chk1({tag, ".dc_resp_valid"}, o_dc_resp_valid, exp_dc);
        chkw({tag, ".resp_data"}, exp_dc ? o_dc_resp_data : o_ic_resp_data, exp_resp);
        chk1({tag, ".idle"}, o_busy, 1'b0);
    endtask

    logic [LINE_W-1:0] rd;
    logic [LINE_W-1:0] wb_data;

    // Randomized-phase bookkeeping.
    int   acc, rsp, cyc, phase, ic_wait, dc_wait;
    bit   own_dc, own_we, ep_ic, ep_dc, ic_hs, dc_hs;
    logic [LINE_W-1:0] ep_data;

    initial begin
        i_reset = 1'b0;
        ic_v = 1'b0; ic_addr = '0;
        dc_v = 1'b0; dc_addr = '0; dc_we = 1'b0; dc_wdata = '0;
        mem_rdy = 1'b0; resp_v = 1'b0; resp_data = '0;
        tick(); tick();

        // Reset state.
        chk1("rst.busy", o_busy, 1'b0);
        chk1("rst.mem_valid", o_mem_req_valid, 1'b0);
        chk1("rst.ic_resp", o_ic_resp_valid, 1'b0);
        chk1("rst.dc_resp", o_dc_resp_valid, 1'b0);
        chk1("rst.owner", o_owner_dc, 1'b0);
        chkw("rst.addr", LINE_W'(o_mem_addr), '0);
        chkw("rst.dc_data", o_dc_resp_data, '0);
        i_reset = 1'b1;

        // Single I-cache fill, memory ready immediately, response two cycles later.
        ic_v = 1'b1; ic_addr = 32'h0000_1000;
        rd = 128'hDEADBEEF_01234567_89ABCDEF_00000001;
        run_txn(1'b0, 32'h0000_1000, 1'b0, '0, 0, 1, rd, rd, "ic_fill");
        tick();
        chk1("ic_fill.pulse_end", o_ic_resp_valid, 1'b0);
        chk1("ic_fill.dc_quiet", o_dc_resp_valid, 1'b0);

        // Ties after a fresh reset: D-cache first, then strict alternation.
        i_reset = 1'b0; tick(); i_reset = 1'b1;
        ic_addr = 32'h0000_3000; dc_addr = 32'h0000_4000; dc_we = 1'b0;
        for (int r = 0; r < 8; r++) begin
            ic_v = 1'b1; dc_v = 1'b1;
            rd = {4{$urandom}};
            if (r % 2 == 0)
                run_txn(1'b1, 32'h0000_4000, 1'b0, '0, 0, 0, rd, rd, $sformatf("tie%0d", r));
            else
                run_txn(1'b0, 32'h0000_3000, 1'b0, '0, 0, 0, rd, rd, $sformatf("tie%0d", r));
        end
        ic_v = 1'b0; dc_v = 1'b0;
        tick();
        chk1("tie.drained", o_busy, 1'b0);

        // Write-back with a 4-cycle memory stall; the ack carries zero data.
        wb_data = {16{8'hA5}};
        dc_v = 1'b1; dc_addr = 32'h0000_2000; dc_we = 1'b1; dc_wdata = wb_data;
        run_txn(1'b1, 32'h0000_2000, 1'b1, wb_data, 4, 1, {4{32'hFFFF_0000}}, '0, "wb");
        dc_we = 1'b0; dc_wdata = '0;
        tick();
        chk1("wb.pulse_end", o_dc_resp_valid, 1'b0);

        // Spurious memory response while IDLE.
        resp_v = 1'b1; resp_data = {4{32'h1234_5678}};
        tick();
        resp_v = 1'b0;
        chk1("spur_idle.ic", o_ic_resp_valid, 1'b0);
        chk1("spur_idle.dc", o_dc_resp_valid, 1'b0);
        chk1("spur_idle.busy", o_busy, 1'b0);

        // Spurious memory response while in REQ.
        ic_v = 1'b1; ic_addr = 32'h0000_5000;
        tick();
        ic_v = 1'b0;
        resp_v = 1'b1;
        tick();
        resp_v = 1'b0;
        chk1("spur_req.still_req", o_mem_req_valid, 1'b1);
        chk1("spur_req.ic", o_ic_resp_valid, 1'b0);
        chk1("spur_req.dc", o_dc_resp_valid, 1'b0);
        mem_rdy = 1'b1; tick(); mem_rdy = 1'b0;
        rd = {4{32'hCAFE_F00D}};
        resp_v = 1'b1; resp_data = rd; tick(); resp_v = 1'b0;
        chk1("spur_req.done", o_ic_resp_valid, 1'b1);
        chkw("spur_req.data", o_ic_resp_data, rd);

        // Reset while waiting in RESP aborts the transaction.
        ic_v = 1'b1; ic_addr = 32'h0000_6000;
        tick();
        ic_v = 1'b0;
        mem_rdy = 1'b1; tick(); mem_rdy = 1'b0;
        chk1("abort.in_resp", o_busy, 1'b1);
        i_reset = 1'b0;
        #1;
        chk1("abort.busy", o_busy, 1'b0);
        chkw("abort.addr", LINE_W'(o_mem_addr), '0);
        tick();
        i_reset = 1'b1;
        resp_v = 1'b1; resp_data = {4{32'hBAD0_BAD0}};
        tick();
        resp_v = 1'b0;
        chk1("abort.ic_resp", o_ic_resp_valid, 1'b0);
        chk1("abort.dc_resp", o_dc_resp_valid, 1'b0);
        chk1("abort.idle", o_busy, 1'b0);
        dc_v = 1'b1; dc_addr = 32'h0000_7000; dc_we = 1'b0;
        rd = {4{32'h0BAD_CAFE}};
        run_txn(1'b1, 32'h0000_7000, 1'b0, '0, 1, 2, rd, rd, "post_abort");
        tick();

        // Randomized traffic with random memory latency.
        acc = 0; rsp = 0; cyc = 0; phase = 0; ic_wait = 0; dc_wait = 0;
        ep_ic = 1'b0; ep_dc = 1'b0; ep_data = '0; own_dc = 1'b0; own_we = 1'b0;
        while ((acc < 1000 || phase != 0 || ep_ic || ep_dc || ic_v || dc_v) && cyc < 60000) begin
            chk1("rnd.ic_resp", o_ic_resp_valid, ep_ic);
            chk1("rnd.dc_resp", o_dc_resp_valid, ep_dc);
            if (ep_ic) chkw("rnd.ic_data", o_ic_resp_data, ep_data);
            if (ep_dc) chkw("rnd.dc_data", o_dc_resp_data, ep_data);
            if (o_ic_resp_valid || o_dc_resp_valid) rsp++;
            ep_ic = 1'b0; ep_dc = 1'b0;
            chk1("rnd.mem_valid", o_mem_req_valid, phase == 1);
            chk1("rnd.busy", o_busy, phase != 0);

            if (acc < 1000 && !ic_v && ($urandom % 2) == 1) begin
                ic_v = 1'b1; ic_addr = $urandom;
            end
            if (acc < 1000 && !dc_v && ($urandom % 2) == 1) begin
                dc_v = 1'b1; dc_addr = $urandom; dc_we = 1'($urandom % 2);
                dc_wdata = {4{$urandom}};
            end
            mem_rdy   = (($urandom % 3) == 0);
            resp_v    = (phase == 2) && (($urandom % 3) == 0);
            resp_data = {4{$urandom}};
            #1;
            chk1("rnd.ready_idle_only", (o_ic_req_ready | o_dc_req_ready) && phase != 0, 1'b0);
            chk1("rnd.grant_when_idle", o_ic_req_ready | o_dc_req_ready, (phase == 0) && (ic_v || dc_v));
            chk1("rnd.ic_ready_needs_valid", o_ic_req_ready & ~ic_v, 1'b0);
            chk1("rnd.dc_ready_needs_valid", o_dc_req_ready & ~dc_v, 1'b0);
            ic_hs = ic_v && o_ic_req_ready;
            dc_hs = dc_v && o_dc_req_ready;
            case (phase)
                0: if (ic_hs || dc_hs) begin
                    phase  = 1;
                    own_dc = dc_hs;
                    own_we = dc_hs && dc_we;
                    acc++;
                    if (dc_hs) begin
                        if (ic_v) ic_wait++;
                        dc_wait = 0;
                        chk1("rnd.ic_wait", ic_wait > 1, 1'b0);
                    end else begin
                        if (dc_v) dc_wait++;
                        ic_wait = 0;
                        chk1("rnd.dc_wait", dc_wait > 1, 1'b0);
                    end
                end
                1: if (mem_rdy) phase = 2;
                default: if (resp_v) begin
                    phase   = 0;
                    ep_dc   = own_dc;
                    ep_ic   = !own_dc;
                    ep_data = own_we ? '0 : resp_data;
                end
            endcase
            tick();
            if (ic_hs) ic_v = 1'b0;
            if (dc_hs) dc_v = 1'b0;
            resp_v  = 1'b0;
            mem_rdy = 1'b0;
            cyc++;
        end
        chk1("rnd.no_timeout", cyc < 60000, 1'b1);
        chkw("rnd.resp_count", LINE_W'(rsp), LINE_W'(acc));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter and sequencer that shares the single memory-controller port between the instruction cache (read-only line fills) and the data cache (line fills and write-backs). It sits between both cache controllers and the memory controller. It accepts one request at a time, latches it, drives it to memory, waits for the response and routes the response back to the requester that issued it. Arbitration is fair round-robin, so neither fetch nor load/store traffic can starve the other.

## Interface
- XLEN, 32, address width
- LINE_W, 128, cache line / memory transfer width in bits
- i_clk  in  1  clock, all state on rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_ic_req_valid  in  1  I-cache read request
- o_ic_req_ready  out  1  I-cache request accepted this cycle
- i_ic_addr  in  XLEN  I-cache line address
- o_ic_resp_valid  out  1  one-cycle pulse, I-cache response data valid
- o_ic_resp_data  out  LINE_W  fill data returned to the I-cache
- i_dc_req_valid  in  1  D-cache request
- o_dc_req_ready  out  1  D-cache request accepted this cycle
- i_dc_addr  in  XLEN  D-cache line address
- i_dc_we  in  1  1 = write-back, 0 = fill
- i_dc_wdata  in  LINE_W  write-back data
- o_dc_resp_valid  out  1  one-cycle pulse, D-cache response (read data or write ack)
- o_dc_resp_data  out  LINE_W  fill data returned to the D-cache; 0 for write acks
- o_mem_req_valid  out  1  request to the memory controller
- i_mem_req_ready  in  1  memory controller accepts the request
- o_mem_addr  out  XLEN  latched address
- o_mem_we  out  1  latched write enable (always 0 for I-cache requests)
- o_mem_wdata  out  LINE_W  latched write data (0 for reads)
- i_mem_resp_valid  in  1  memory response strobe
- i_mem_resp_data  in  LINE_W  memory read data
- o_busy  out  1  state is not IDLE
- o_owner_dc  out  1  owner of the current transaction (1 = D-cache)

## Operation
- FSM states: IDLE, REQ, RESP.
- **IDLE**
  - Arbitration, combinational:
    - Only one valid: that requester wins.
    - Both valid: the requester not granted last wins (round-robin).
  - Winner's ready = 1 and the loser's ready = 0. Both readies are 0 in every other state.
  - On valid&&ready, latch addr/we/wdata and the owner, update the last-grant flag, then go to REQ.
  - I-cache requests latch we=0 and wdata=0.
- **REQ**
  - o_mem_req_valid=1 with the latched fields held stable.
  - On i_mem_req_ready, go to RESP.
- **RESP**
  - Wait for i_mem_resp_valid.
  - When it arrives, register the owner's resp_valid=1 and resp_data for the next cycle (D-cache write → data 0), then go to IDLE.
- i_mem_resp_valid outside RESP is ignored.
- i_mem_resp_data is sampled only with i_mem_resp_valid.
- Requesters must hold valid and their fields stable until ready. Deasserting valid before ready is legal: nothing is issued.
- Last-grant flag resets to "I-cache", so the first tie goes to the D-cache.
- Only one transaction is outstanding at a time; there is no queue.

## Timing
- Reset (asynchronous, active-low): state=IDLE, last-grant=I-cache, all latched fields 0, every output register 0.
  - Combinational readies follow the valids once reset is released.
- Reset mid-transaction aborts it:
  - No response pulse is produced.
  - A late i_mem_resp_valid is ignored.
- Cycle 0: IDLE handshake.
- Cycle 1: o_mem_req_valid=1, owner stable.
- Memory ready in cycle n ≥ 1: RESP from cycle n+1.
- Memory response in cycle k ≥ n+1: o_*_resp_valid in cycle k+1.
  - The state is already IDLE in cycle k+1, so a new grant may occur in that same cycle.
- Minimum accept-to-response is 3 cycles.
- Back-to-back throughput is one transaction per 3 cycles minimum.
- resp_valid pulses last exactly 1 cycle.
- o_ic_resp_valid and o_dc_resp_valid are never both 1.
- A requester that asserts valid while the other is in flight waits. It is granted in the first IDLE cycle, which is the response cycle of the previous transaction.

## Test plan
- Reset release, then I-cache read addr 0x0000_1000; memory ready immediately and response 0xDEADBEEF_..._01 two cycles later.
  - o_ic_req_ready in cycle 0, o_mem_req_valid in cycle 1 with addr 0x1000 and we=0.
  - o_ic_resp_valid one cycle after the memory response, data matching.
  - o_dc_resp_valid stays 0.
- Both valid in the same cycle, first time after reset.
  - D-cache wins, then the I-cache is served next.
  - Repeat the tie: the D-cache wins again. Strict alternation holds over 8 tied rounds.
- D-cache write-back addr 0x2000 with wdata 0xA5 repeated; memory holds i_mem_req_ready low for 4 cycles.
  - o_mem_req_valid held with stable addr/we=1/wdata through all 4 stall cycles.
  - o_dc_resp_valid with data 0 after the response.
- Spurious i_mem_resp_valid while IDLE and during REQ → no resp pulse and no state change.
- Assert i_reset low during RESP, then release; memory response arrives afterwards.
  - No resp pulse; o_busy=0.
  - The next request is served normally.
- Random valids from both caches over 1000 transactions with random memory latency.
  - Every accepted request gets exactly one response, routed to its owner.
  - Neither requester waits longer than one other transaction.
